// File: rtl/dspb_serum_onchip_ram_pipelined.sv
// dspb_serum_onchip_ram_pipelined: parametrised Avalon-MM on-chip RAM slave
// with pipelined reads (readdatavalid), waitrequest, clock enable and zeroize.
//
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   clken                 global clock enable; 0 stalls the whole block
//   address, byteenable   word address and write byte lanes
//   chipselect, read,
//   write, writedata      Avalon-MM command
//   readdata,
//   readdatavalid         read response, one pulse per accepted read
//   waitrequest           1 = command not accepted this cycle
//   clear_req, clear_busy zeroize request pulse / zeroize in progress
module dspb_serum_onchip_ram_pipelined #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int READ_LATENCY   = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    input  logic                    clear_req,
    output logic                    clear_busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("READ_LATENCY must be 1 or 2");
        end
        if (DATA_WIDTH % 8 != 0) begin : g_bad_width
            $error("DATA_WIDTH must be a multiple of 8");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    accept;
    logic                    accept_wr;
    logic                    accept_rd;
    logic                    pipe_valid;
    logic [DATA_WIDTH-1:0]   pipe_data;
    logic                    rvalid;

    assign clear_busy  = (state == CLEAR);
    assign waitrequest = (state == CLEAR) | ~clken;
    assign accept      = chipselect & (read | write) & ~waitrequest;
    assign accept_wr   = accept & write;
    // A simultaneous read is dropped in favour of the write.
    assign accept_rd   = accept & read & ~write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RESET_STATE;
            clr_cnt <= '0;
        end else if (clken) begin
            state <= state_next;
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (clear_req) state_next = CLEAR;
            CLEAR: if (clr_cnt == '1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Storage has no reset; zeroize clears it one word per enabled cycle.
    always_ff @(posedge clk) begin
        if (clken) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (accept_wr) begin
                for (int b = 0; b < NB; b++) begin
                    if (byteenable[b]) begin
                        mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Data is captured at acceptance, so reads in flight when a clear
    // starts still return pre-clear contents.
    assign rd_word = mem[address];

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  s1_valid;
            logic [DATA_WIDTH-1:0] s1_data;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                end else if (clken) begin
                    s1_valid <= accept_rd;
                    if (accept_rd) begin
                        s1_data <= rd_word;
                    end
                end
            end

            assign pipe_valid = s1_valid;
            assign pipe_data  = s1_data;
        end else begin : g_lat1
            assign pipe_valid = accept_rd;
            assign pipe_data  = rd_word;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid   <= 1'b0;
            readdata <= '0;
        end else if (clken) begin
            rvalid <= pipe_valid;
            if (pipe_valid) begin
                readdata <= pipe_data;
            end
        end
    end

    // The held response stays in rvalid during a stall and is shown in the
    // first enabled cycle, then replaced at that cycle's edge.
    assign readdatavalid = rvalid & clken;

endmodule

// File: tb/tb_dspb_serum_onchip_ram_pipelined.sv
// tb_dspb_serum_onchip_ram_pipelined: directed self-checking bench for
// the pipelined on-chip RAM (32-bit x 16 words, latency 2, clear on reset).
module tb_dspb_serum_onchip_ram_pipelined;

    logic        clk;
    logic        reset;
    logic        clken;
    logic [3:0]  address;
    logic [3:0]  byteenable;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;
    logic        clear_req;
    logic        clear_busy;

    int          n_cmp;
    int          n_bad;
    int          n;
    logic [31:0] model [16];

    dspb_serum_onchip_ram_pipelined #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (4),
        .READ_LATENCY   (2),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clken         (clken),
        .address       (address),
        .byteenable    (byteenable),
        .chipselect    (chipselect),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest),
        .clear_req     (clear_req),
        .clear_busy    (clear_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (clear_busy && cnt < 100) begin
            check("busy_wreq", 32'(waitrequest), 32'd1);
            check("busy_rdv", 32'(readdatavalid), 32'd0);
            cnt++;
            tick();
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        byteenable = be;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [3:0] a,
                            input logic [31:0] exp);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        tick();
        chipselect = 1'b0;
        read       = 1'b0;
        check({tag, "_n1"}, 32'(readdatavalid), 32'd0);
        tick();
        check({tag, "_n2"}, 32'(readdatavalid), 32'd1);
        check({tag, "_data"}, readdata, exp);
    endtask

    task automatic burst(input int base, input int cnt);
        int j;
        for (int i = 0; i <= cnt + 1; i++) begin
            if (i < cnt) begin
                chipselect = 1'b1;
                read       = 1'b1;
                address    = 4'(base + i);
            end else begin
                chipselect = 1'b0;
                read       = 1'b0;
            end
            tick();
            j = i - 1;
            if (j >= 0 && j < cnt) begin
                check("burst_rdv", 32'(readdatavalid), 32'd1);
                check("burst_data", readdata, model[base + j]);
            end else begin
                check("burst_gap", 32'(readdatavalid), 32'd0);
            end
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b1;
        clken      = 1'b1;
        address    = '0;
        byteenable = '0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        clear_req  = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;

        // Reset values and power-up clear length
        #2;
        check("rst_rdv", 32'(readdatavalid), 32'd0);
        check("rst_rdata", readdata, 32'h0);
        check("rst_wreq", 32'(waitrequest), 32'd1);
        check("rst_busy", 32'(clear_busy), 32'd1);
        tick();
        reset = 1'b0;
        count_busy(n);
        check("clr_len_por", n, 32'd16);
        check("idle_wreq", 32'(waitrequest), 32'd0);
        burst(0, 16);

        // Byte-enable merge
        wr(4'd5, 32'h11223344, 4'b1111);
        wr(4'd5, 32'hDEADBEEF, 4'b0101);
        rd_check("be_merge", 4'd5, 32'h11AD33EF);

        // Back-to-back reads 0..7
        for (int i = 0; i < 8; i++) begin
            wr(4'(i), 32'hC0DE_0000 + 32'(i * 32'h111), 4'b1111);
        end
        model[0] = 32'hC0DE0000;
        model[1] = 32'hC0DE0111;
        model[2] = 32'hC0DE0222;
        model[3] = 32'hC0DE0333;
        model[4] = 32'hC0DE0444;
        model[5] = 32'hC0DE0555;
        model[6] = 32'hC0DE0666;
        model[7] = 32'hC0DE0777;
        burst(0, 8);

        // Stall with two reads in flight
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 4'd1;
        tick();
        address    = 4'd2;
        tick();
        chipselect = 1'b0;
        read       = 1'b0;
        clken      = 1'b0;
        #1;
        check("stall_rdv0", 32'(readdatavalid), 32'd0);
        check("stall_wreq", 32'(waitrequest), 32'd1);
        tick();
        check("stall_rdv1", 32'(readdatavalid), 32'd0);
        tick();
        check("stall_rdv2", 32'(readdatavalid), 32'd0);
        tick();
        clken = 1'b1;
        #1;
        check("resume_rdv_a", 32'(readdatavalid), 32'd1);
        check("resume_data_a", readdata, 32'hC0DE0111);
        tick();
        check("resume_rdv_b", 32'(readdatavalid), 32'd1);
        check("resume_data_b", readdata, 32'hC0DE0222);
        tick();
        check("resume_once", 32'(readdatavalid), 32'd0);
        check("hold_rdata", readdata, 32'hC0DE0222);

        // clear_req together with a write
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 4'd3;
        writedata  = 32'hA5A5A5A5;
        byteenable = 4'b1111;
        clear_req  = 1'b1;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
        clear_req  = 1'b0;
        check("clrreq_busy", 32'(clear_busy), 32'd1);
        count_busy(n);
        check("clr_len_req", n, 32'd16);
        rd_check("clr_a3", 4'd3, 32'h0);
        rd_check("clr_a1", 4'd1, 32'h0);

        // Reset with a read in flight
        wr(4'd9, 32'h12345678, 4'b1111);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 4'd9;
        tick();
        chipselect = 1'b0;
        read       = 1'b0;
        reset      = 1'b1;
        #1;
        check("rstrd_rdv", 32'(readdatavalid), 32'd0);
        check("rstrd_rdata", readdata, 32'h0);
        tick();
        reset = 1'b0;
        count_busy(n);
        check("clr_len_rst1", n, 32'd16);
        check("rstrd_after", 32'(readdatavalid), 32'd0);

        // Reset mid-clear at counter 7
        wr(4'd9, 32'h0BADF00D, 4'b1111);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("mid_busy", 32'(clear_busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(clear_busy), 32'd1);
        tick();
        reset = 1'b0;
        count_busy(n);
        check("clr_len_rst2", n, 32'd16);
        rd_check("mid_a9", 4'd9, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dspb_serum_onchip_ram_pipelined.md
Name: dspb_serum_onchip_ram_pipelined

Overview:
- Parametrised Avalon-MM on-chip RAM slave; next generation of the fixed 32-bit x 64K single-port SRAM.
- Adds configurable width, depth and read latency, with a readdatavalid/waitrequest pipelined handshake.
- Adds a built-in zeroize engine that clears the array after reset or on request.
- Sits on the Qsys data fabric as general scratch/sample buffer memory for the DSP-B serum datapath.

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8.
ADDR_WIDTH, 16, word address width; DEPTH = 2**ADDR_WIDTH.
READ_LATENCY, 2, accepted-read to readdatavalid, in enabled cycles; legal values 1 or 2, anything else is a elaboration error.
CLEAR_ON_RESET, 1, 1 = run zeroize automatically after reset release; 0 = contents undefined after power-up.

Ports:
clk  in  1  single clock.
reset  in  1  asynchronous, active-high.
clken  in  1  global clock enable; 0 stalls the whole block.
address  in  ADDR_WIDTH  word address.
byteenable  in  DATA_WIDTH/8  byte lanes for writes.
chipselect  in  1  slave select.
read  in  1  read request.
write  in  1  write request.
writedata  in  DATA_WIDTH  write data.
readdata  out  DATA_WIDTH  read response data.
readdatavalid  out  1  readdata valid, one cycle per accepted read.
waitrequest  out  1  1 = command not accepted this cycle.
clear_req  in  1  single-cycle pulse requesting a zeroize.
clear_busy  out  1  1 while zeroize is running.

Behaviour:
- Reset (async assert): readdata=0, readdatavalid=0, read pipeline valid bits=0, clear counter=0.
- Reset values: state=CLEAR and clear_busy=1 if CLEAR_ON_RESET=1; else state=IDLE and clear_busy=0.
- waitrequest = (state==CLEAR) | ~clken; combinational, no dependence on read/write.
- Accept: chipselect & (read|write) & ~waitrequest.
- Accepted write: bytes whose byteenable bit is set are updated at the clock edge; all other bytes are unchanged.
- Accepted read: the read is issued into the response pipeline.
- read and write both set in one accepted cycle: the write is performed; the read is dropped and produces no readdatavalid.
- Read latency: a read accepted at enabled cycle N returns readdatavalid=1 and its data at enabled cycle N+READ_LATENCY.
- Fully pipelined: one read per cycle sustained; responses return in order.
- Write-then-read ordering: a write at cycle N followed by a read of the same address at N+1 returns the new data.
- clken=0: RAM, pipeline, clear counter and FSM all hold state; readdatavalid is forced to 0 for that cycle.
- clken=0 response delivery: a held response is presented in the first cycle with clken=1, exactly once, never duplicated.
- readdata holds its last value when readdatavalid=0.
- FSM state IDLE: normal operation.
  - clear_req=1 with clken=1 moves to CLEAR next cycle; a command accepted in that same cycle still executes.
  - Reads in flight complete with pre-clear data.
- FSM state CLEAR: writes zero to the word at the counter address, then increments the counter, each enabled cycle.
  - Counter at DEPTH-1: that word is written, the counter wraps to 0, and the FSM moves to IDLE.
  - Clear therefore takes exactly DEPTH enabled cycles.
  - clear_req during CLEAR is ignored; the clear does not restart.
- clear_busy = (state==CLEAR).
- Reset asserted mid-clear or mid-read: in-flight reads are discarded with no readdatavalid; the clear restarts from address 0 if CLEAR_ON_RESET=1.
- Address is not range-checked beyond ADDR_WIDTH; there is no wrap logic beyond natural truncation.

Test Plan:
- Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=4: waitrequest=1 and clear_busy=1 for exactly 16 cycles. Then read all 16 addresses -> every readdata=0.
- READ_LATENCY=2, DATA_WIDTH=32: write 0xDEADBEEF to addr 5 with byteenable=4'b0101, over prior 0x11223344. Read addr 5 -> readdatavalid 2 cycles later with 0x11AD33EF.
- Back-to-back reads of addrs 0..7, one per cycle -> 8 consecutive readdatavalid pulses, in order, with correct data and no gaps.
- clken low for 3 cycles while 2 reads are in flight -> readdatavalid=0 during the stall. Each response is delivered exactly once after clken returns; total enabled-cycle latency stays 2.
- clear_req pulsed in the same cycle as a write of 0xA5A5A5A5 to addr 3 -> write happens, then clear runs 16 cycles. Read addr 3 -> 0.
- Assert reset at clear counter=7 -> on release the clear restarts at 0 and still takes 16 cycles. A read in flight at reset never returns readdatavalid.
